reload_down_counter: RTL

RELOAD_DOWN_COUNTER -- requirements
Module: reload_down_counter

---
 rtl/reload_down_pkg.sv | 25 ++
 rtl/reload_down_counter_if.sv | 50 +++++
 rtl/reload_prescaler.sv | 41 ++++
 rtl/reload_down_counter.sv | 116 +++++++++++
 4 files changed

// File: rtl/reload_down_pkg.sv
// Shared types and defaults for the reload down-counter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DEFAULT_WIDTH      default counter / reload value width in bits
//   DEFAULT_PRESCALE   default divide ratio minus one for the optional prescaler
//   state_t            two-state controller encoding (IDLE, RUN)
//   prescale_cnt_width width of the prescaler phase counter for a given ratio
package reload_down_pkg;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A prescale of 0 still needs a one-bit counter so the vector is legal.
  function automatic int unsigned prescale_cnt_width(input int unsigned prescale);
    return (prescale > 0) ? $clog2(prescale + 1) : 1;
  endfunction

endpackage

// File: rtl/reload_down_counter_if.sv
// Control/status bundle between a host and the reload down-counter.
// Latency: none (wires only).
// Backpressure: none; every input is sampled on the clock it is presented.
//
// Signals:
//   load_i, load_val_i  write a new reload value
//   start_i, stop_i     begin / abort counting
//   oneshot_i           mode sampled on start (1 = stop at expiry)
//   count_o             current count
//   expire_o            one-cycle pulse when a zero count is consumed
//   busy_o              counter is running
// Modports: master = host side, slave = counter side.
interface reload_down_counter_if
  import reload_down_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic             start_i;
  logic             stop_i;
  logic             oneshot_i;
  logic [WIDTH-1:0] count_o;
  logic             expire_o;
  logic             busy_o;

  modport master (
    output load_i,
    output load_val_i,
    output start_i,
    output stop_i,
    output oneshot_i,
    input  count_o,
    input  expire_o,
    input  busy_o
  );

  modport slave (
    input  load_i,
    input  load_val_i,
    input  start_i,
    input  stop_i,
    input  oneshot_i,
    output count_o,
    output expire_o,
    output busy_o
  );

endinterface

// File: rtl/reload_prescaler.sv
// Count-enable divider: one tick every PRESCALE+1 enabled cycles.
// Latency: tick is combinational from the phase register; first tick PRESCALE cycles after clear.
// Backpressure: none; enable simply freezes the phase.
//
// Only built when RELOAD_DOWN_PRESCALE_EN is defined; otherwise this file is empty.
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-high reset, phase -> 0
//   enable  advance the phase this cycle
//   clear   restart the phase at 0 (wins over enable)
//   tick    high on the last phase of each period while enabled
`ifdef RELOAD_DOWN_PRESCALE_EN
module reload_prescaler
  import reload_down_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = prescale_cnt_width(PRESCALE);
  localparam logic [CW-1:0] TERM = CW'(PRESCALE);

  logic [CW-1:0] phase_q;

  assign tick = enable && (phase_q == TERM);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= tick ? '0 : phase_q + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/reload_down_counter.sv
// Loadable down-counter with one-shot or periodic reload and an expiry pulse.
// Latency: load/start/stop act on the next clock; expire_o is combinational in the zero cycle.
// Backpressure: none; all controls are accepted every cycle (stop beats start).
//
// Optional feature: define RELOAD_DOWN_PRESCALE_EN to divide the count enable by
// PRESCALE+1 through reload_prescaler; undefined, the count steps every RUN cycle.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   bus    reload_down_counter_if.slave (load/start/stop/mode in, count/expire/busy out)
module reload_down_counter
  import reload_down_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef RELOAD_DOWN_PRESCALE_EN
  ,
  parameter int PRESCALE = DEFAULT_PRESCALE
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  reload_down_counter_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             oneshot_q, oneshot_d;
  logic             expire;
  logic             count_en;
  logic             run_entry;
  logic             run_stop;

  assign run_entry = (state_q == IDLE) && bus.start_i && !bus.stop_i;
  assign run_stop  = (state_q == RUN) && bus.stop_i;

`ifdef RELOAD_DOWN_PRESCALE_EN
  // Phase restarts whenever a run begins or is aborted, so every run sees
  // a full first period.
  reload_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == RUN),
    .clear  (run_entry || run_stop),
    .tick   (count_en)
  );
`else
  assign count_en = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    oneshot_d = oneshot_q;
    expire    = 1'b0;

    // The reload register accepts a write in any state.
    if (bus.load_i) begin
      reload_d = bus.load_val_i;
    end

    case (state_q)
      IDLE: begin
        if (bus.load_i) begin
          count_d = bus.load_val_i;
        end
        if (run_entry) begin
          state_d   = RUN;
          oneshot_d = bus.oneshot_i;
        end
      end

      RUN: begin
        if (bus.stop_i) begin
          // Abort: count freezes and a pending zero never expires.
          state_d = IDLE;
        end else if (count_en) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            expire = 1'b1;
            if (oneshot_q) begin
              state_d = IDLE;
            end else begin
              // reload_d already carries a same-cycle load, giving the bypass.
              count_d = reload_d;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      oneshot_q <= oneshot_d;
    end
  end

  assign bus.count_o  = count_q;
  assign bus.busy_o   = (state_q == RUN);
  // Reset overrides everything, including the combinational pulse.
  assign bus.expire_o = expire && !reset;

endmodule
